// File: rtl/stream_rr_arbiter.sv
// Merges NumInputs valid/ready streams onto one registered output stream with
// packet-aware round-robin arbitration: a granted input keeps the output until its last beat.
module stream_rr_arbiter #(
    parameter int NumInputs = 4,
    parameter int DataBits  = 8,
    localparam int SrcBits  = (NumInputs > 2) ? $clog2(NumInputs) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumInputs-1:0]          din_valid,
    output logic [NumInputs-1:0]          din_ready,
    input  logic [NumInputs*DataBits-1:0] din_data,
    input  logic [NumInputs-1:0]          din_last,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [DataBits-1:0]           dout_data,
    output logic                          dout_last,
    output logic [SrcBits-1:0]            dout_src
);
    localparam int IdxBits = SrcBits + 1;
    localparam logic [IdxBits-1:0] NumIdx  = IdxBits'(NumInputs);
    localparam logic [SrcBits-1:0] LastIdx = SrcBits'(NumInputs - 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]          state_reg;
    logic [SrcBits-1:0]  grant_reg;
    logic [SrcBits-1:0]  rr_ptr_reg;
    logic                dout_valid_reg;
    logic [DataBits-1:0] dout_data_reg;
    logic                dout_last_reg;
    logic [SrcBits-1:0]  dout_src_reg;

    logic                locked;
    logic [IdxBits-1:0]  cand;
    logic [SrcBits-1:0]  search_sel;
    logic                search_hit;
    logic [SrcBits-1:0]  sel;
    logic                sel_ok;
    logic                load_ok;
    logic                acc;
    logic                sel_last;
    logic [DataBits-1:0] din_slice [NumInputs];

    function automatic logic [SrcBits-1:0] wrap_inc(input logic [SrcBits-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    assign locked = (state_reg == ST_LOCKED);

    // Rotating-priority search starting at rr_ptr; the wrap is an explicit
    // compare so non-power-of-two input counts work.
    always_comb begin
        cand       = '0;
        search_sel = '0;
        search_hit = 1'b0;
        for (int k = 0; k < NumInputs; k++) begin
            cand = {1'b0, rr_ptr_reg} + IdxBits'(k);
            if (cand >= NumIdx) begin
                cand = cand - NumIdx;
            end
            if (!search_hit && din_valid[cand[SrcBits-1:0]]) begin
                search_hit = 1'b1;
                search_sel = cand[SrcBits-1:0];
            end
        end
    end

    assign sel      = locked ? grant_reg : search_sel;
    assign sel_ok   = locked | search_hit;
    assign load_ok  = !dout_valid_reg | dout_ready;
    assign acc      = |(din_valid & din_ready);
    assign sel_last = din_last[sel];

    generate
        for (genvar gi = 0; gi < NumInputs; gi++) begin : g_in
            assign din_slice[gi] = din_data[gi*DataBits +: DataBits];
            // Gated by rst so valid inputs are ignored while reset is held.
            assign din_ready[gi] = rst & sel_ok & load_ok & (sel == SrcBits'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_UNLOCKED;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            dout_valid_reg <= 1'b0;
            dout_data_reg  <= '0;
            dout_last_reg  <= 1'b0;
            dout_src_reg   <= '0;
        end else begin
            if (acc) begin
                dout_valid_reg <= 1'b1;
                dout_data_reg  <= din_slice[sel];
                dout_last_reg  <= sel_last;
                dout_src_reg   <= sel;
            end else if (dout_ready) begin
                dout_valid_reg <= 1'b0;
            end

            if (acc) begin
                case (state_reg)
                    ST_UNLOCKED: begin
                        if (!sel_last) begin
                            state_reg <= ST_LOCKED;
                            grant_reg <= sel;
                        end else begin
                            rr_ptr_reg <= wrap_inc(sel);
                        end
                    end
                    default: begin
                        if (sel_last) begin
                            state_reg  <= ST_UNLOCKED;
                            rr_ptr_reg <= wrap_inc(grant_reg);
                        end
                    end
                endcase
            end
        end
    end

    assign dout_valid = dout_valid_reg;
    assign dout_data  = dout_data_reg;
    assign dout_last  = dout_last_reg;
    assign dout_src   = dout_src_reg;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: randomized and directed traffic checked every cycle
// against a packet-level arbitration model, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    din_valid, din_ready, din_last;
    logic [N*DW-1:0] din_data;
    logic            dout_valid, dout_ready, dout_last;
    logic [DW-1:0]   dout_data;
    logic [SW-1:0]   dout_src;

    stream_rr_arbiter #(.NumInputs(N), .DataBits(DW)) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .dout_src(dout_src)
    );

    // Three-input instance for the non-power-of-two wrap scenario.
    logic        rst3;
    logic [2:0]  v3, r3, l3;
    logic [23:0] d3;
    logic        ov3, or3, ol3;
    logic [7:0]  od3;
    logic [1:0]  os3;

    stream_rr_arbiter #(.NumInputs(3), .DataBits(8)) dut3 (
        .clk(clk), .rst(rst3),
        .din_valid(v3), .din_ready(r3), .din_data(d3), .din_last(l3),
        .dout_valid(ov3), .dout_ready(or3), .dout_data(od3),
        .dout_last(ol3), .dout_src(os3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    typedef struct {
        int src;
        int data;
        int last;
        int cyc;
    } ob_t;

    beat_t srcq [N][$];
    ob_t   olog [$];
    logic [N-1:0] hs_vec;
    int rdy_mode;
    int ncyc;

    task automatic push_beat(input int i, input logic [7:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        srcq[i].push_back(b);
    endtask

    // Source drivers: hold a beat until it is handshaken, optional gap before each beat.
    initial begin
        logic [N-1:0] presenting;
        int gap_cnt [N];
        int dcyc;
        presenting = '0;
        dcyc = 0;
        din_valid = '0;
        din_last = '0;
        din_data = '0;
        dout_ready = 1'b1;
        for (int i = 0; i < N; i++) gap_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            dcyc++;
            for (int i = 0; i < N; i++) begin
                if (hs_vec[i] && presenting[i]) begin
                    void'(srcq[i].pop_front());
                    presenting[i] = 1'b0;
                end
                if (!presenting[i] && srcq[i].size() > 0) begin
                    if (gap_cnt[i] < srcq[i][0].gap) begin
                        gap_cnt[i]++;
                    end else begin
                        presenting[i] = 1'b1;
                        gap_cnt[i] = 0;
                    end
                end
                din_valid[i] = presenting[i];
                if (presenting[i]) begin
                    din_data[i*DW +: DW] = srcq[i][0].data;
                    din_last[i]          = srcq[i][0].last;
                end else begin
                    din_data[i*DW +: DW] = 8'($urandom);
                    din_last[i]          = 1'($urandom);
                end
            end
            case (rdy_mode)
                1:       dout_ready = ($urandom_range(0, 3) != 0);
                2:       dout_ready = (dcyc % 3 == 0);
                default: dout_ready = 1'b1;
            endcase
        end
    end

    // Model and compare process: at each falling edge compare the DUT against the
    // model, then advance the model to the state after the coming rising edge.
    initial begin
        int m_owner, m_ptr, m_os, g, sb_cur, idx;
        logic m_ov, m_ol, load_ok;
        logic [7:0] m_od;
        logic [N-1:0] exp_rdy;
        ob_t ob;
        m_owner = -1; m_ptr = 0; m_os = 0; m_ov = 0; m_ol = 0; m_od = 0;
        sb_cur = -1; ncyc = 0; hs_vec = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                check("rst_din_ready", din_ready, 0);
                check("rst_dout_valid", dout_valid, 0);
                check("rst_dout_data", dout_data, 0);
                check("rst_dout_src", dout_src, 0);
                m_owner = -1; m_ptr = 0; m_os = 0; m_ov = 0; m_ol = 0; m_od = 0;
                sb_cur = -1; hs_vec = '0;
            end else begin
                check("dout_valid", dout_valid, m_ov);
                check("dout_data", dout_data, m_od);
                check("dout_last", dout_last, m_ol);
                check("dout_src", dout_src, m_os);
                if (dout_valid && dout_ready) begin
                    ob.src = int'(dout_src); ob.data = int'(dout_data);
                    ob.last = int'(dout_last); ob.cyc = ncyc;
                    olog.push_back(ob);
                    if (sb_cur >= 0) check("packet_contiguity", dout_src, sb_cur);
                    sb_cur = dout_last ? -1 : int'(dout_src);
                end
                load_ok = !m_ov || dout_ready;
                g = m_owner;
                if (g < 0) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (g < 0 && din_valid[idx]) g = idx;
                    end
                end
                exp_rdy = '0;
                if (g >= 0 && load_ok) exp_rdy[g] = 1'b1;
                check("din_ready", din_ready, exp_rdy);
                hs_vec = din_valid & din_ready;
                if (g >= 0 && load_ok && din_valid[g]) begin
                    m_ov = 1'b1;
                    m_od = din_data[g*DW +: DW];
                    m_ol = din_last[g];
                    m_os = g;
                    if (din_last[g]) begin
                        m_owner = -1;
                        m_ptr = (g + 1) % N;
                    end else begin
                        m_owner = g;
                    end
                end else if (dout_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    function automatic bit tb_idle();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
        return (din_valid == '0) && !dout_valid;
    endfunction

    task automatic drain(input int budget);
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy = !tb_idle();
        end while (busy && n < budget);
        check("drain_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_log(input string nm, input int i, input int s, input int d, input int l);
        if (i >= olog.size()) begin
            check({nm, "_missing"}, olog.size(), i + 1);
        end else begin
            check({nm, "_src"}, olog[i].src, s);
            check({nm, "_data"}, olog[i].data, d);
            check({nm, "_last"}, olog[i].last, l);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        rst = 1'b0; rst3 = 1'b0;
        v3 = '0; l3 = '0; d3 = '0; or3 = 1'b1;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Fairness: every input offers three single-beat packets at once.
        @(negedge clk);
        olog.delete();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) push_beat(i, 8'(16 * i + k), 1'b1, 0);
        drain(500);
        check("fair_count", olog.size(), 12);
        for (int j = 0; j < 12 && j < olog.size(); j++) begin
            check_log("fair", j, j % 4, 16 * (j % 4) + j / 4, 1);
            if (j > 0) check("fair_back_to_back", olog[j].cyc - olog[j-1].cyc, 1);
        end

        // Packet lock: input 1 three-beat packet, input 2 requests one cycle later.
        olog.delete();
        push_beat(1, 8'h11, 1'b0, 0);
        push_beat(1, 8'h12, 1'b0, 0);
        push_beat(1, 8'h13, 1'b1, 0);
        @(negedge clk);
        push_beat(2, 8'h21, 1'b1, 0);
        drain(500);
        check("lock_count", olog.size(), 4);
        check_log("lock", 0, 1, 'h11, 0);
        check_log("lock", 1, 1, 'h12, 0);
        check_log("lock", 2, 1, 'h13, 1);
        check_log("lock", 3, 2, 'h21, 1);

        // Backpressure: downstream ready pattern 1,0,0 during a 4-beat packet.
        olog.delete();
        rdy_mode = 2;
        for (int b = 0; b < 4; b++) push_beat(3, 8'(8'h31 + b), b == 3, 0);
        drain(500);
        rdy_mode = 0;
        check("bp_count", olog.size(), 4);
        for (int b = 0; b < 4; b++) check_log("bp", b, 3, 'h31 + b, (b == 3) ? 1 : 0);

        // Locked bubble: input 0 goes idle for 5 cycles mid-packet while input 1 waits.
        olog.delete();
        push_beat(0, 8'h01, 1'b0, 0);
        push_beat(0, 8'h02, 1'b0, 0);
        push_beat(0, 8'h03, 1'b0, 5);
        push_beat(0, 8'h04, 1'b1, 0);
        push_beat(1, 8'h41, 1'b1, 0);
        drain(500);
        check("bubble_count", olog.size(), 5);
        check_log("bubble", 0, 0, 'h01, 0);
        check_log("bubble", 1, 0, 'h02, 0);
        check_log("bubble", 2, 0, 'h03, 0);
        check_log("bubble", 3, 0, 'h04, 1);
        check_log("bubble", 4, 1, 'h41, 1);
        if (olog.size() == 5) check("bubble_gap", olog[3].cyc - olog[1].cyc > 5, 1);

        // Reset mid-traffic with all inputs valid; first grant afterwards is input 0.
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < 3; b++) push_beat(i, 8'($urandom), b == 2, 0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        olog.delete();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        if (olog.size() == 0) check("rst_first_grant_missing", olog.size(), 1);
        else check("rst_first_grant_src", olog[0].src, 0);
        drain(2000);

        // Randomized traffic with random gaps and random downstream stalls.
        rdy_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 4 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++)
                        push_beat(i, 8'($urandom), b == len - 1,
                                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                end
            end
        end
        rdy_mode = 0;
        drain(2000);

        // Three-input wrap: move rr_ptr to 2, sparse request from input 1, then wrap to 0.
        @(posedge clk);
        #1 rst3 = 1'b1;
        @(posedge clk);
        #1 v3 = 3'b010; l3 = 3'b010; d3 = 24'h00A100;
        @(negedge clk);
        check("n3_first_ready", r3, 3'b010);
        @(posedge clk);
        #1 v3 = 3'b010; l3 = 3'b000; d3 = 24'h00B100;
        @(negedge clk);
        check("n3_sparse_ready", r3, 3'b010);
        check("n3_first_data", od3, 8'hA1);
        check("n3_first_src", os3, 1);
        @(posedge clk);
        #1 l3 = 3'b010; d3 = 24'h00B200;
        @(negedge clk);
        check("n3_locked_ready", r3, 3'b010);
        check("n3_b1_data", od3, 8'hB1);
        @(posedge clk);
        #1 v3 = 3'b011; l3 = 3'b011; d3 = 24'h00D0C0;
        @(negedge clk);
        check("n3_wrap_ready", r3, 3'b001);
        check("n3_b2_data", od3, 8'hB2);
        check("n3_b2_last", ol3, 1);
        @(posedge clk);
        #1 v3 = 3'b000;
        @(negedge clk);
        check("n3_wrap_src", os3, 0);
        check("n3_wrap_data", od3, 8'hC0);
        check("n3_wrap_valid", ov3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
